regfile_scb: RTL and testbench
==============================

# regfile_scb

Parametrised successor to the core's integer register file. It has a configurable data width, register count and read-port count. Its storage array carries no reset and is cleared after reset by a sequential init sequencer, which lets it map to LUTRAM. It adds a per-register busy scoreboard for the pipeline's issue and writeback stages, and optional write-to-read forwarding. It sits between decode/issue (read and allocate) and writeback (write and release).

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers; power of two, ≥ 4; entry 0 reads as zero
- NRD, 2, number of independent read ports
- AW (localparam), $clog2(NREGS), address width
- clk_i  in  1  clock; all state updates on rising edge
- rst_n_i  in  1  reset, synchronous, active-low
- ready_o  out  1  high once init sequence finished
- rs_i  in  [NRD-1:0][AW-1:0]  read addresses
- rdata_o  out  [NRD-1:0][XLEN-1:0]  read data, combinational
- rs_busy_o  out  [NRD-1:0]  busy status of each addressed register
- we_i  in  1  write enable (writeback)
- waddr_i  in  AW  write address
- wdata_i  in  XLEN  write data
- alloc_i  in  1  issue marks a destination pending
- alloc_rd_i  in  AW  destination being allocated
- flush_i  in  1  clear all busy bits
- busy_o  out  NREGS  full scoreboard vector, registered

## Operation
- FSM states: INIT and RUN.
- Reset (rst_n_i low at an edge):
  - Enter INIT, set init counter to 1, clear busy.
  - While rst_n_i is low: ready_o=0, busy_o=0, rdata_o=0, rs_busy_o=0.
- INIT:
  - Each cycle writes zero to entry [counter], then increments the counter.
  - After writing entry NREGS-1, go to RUN.
  - we_i, alloc_i and flush_i are ignored.
  - rdata_o=0, rs_busy_o=0.
- RUN: ready_o=1.
- Read, per port p:
  - rdata_o[p] = storage[rs_i[p]]; entry 0 always reads 0.
  - rs_busy_o[p] = busy[rs_i[p]]; index 0 is never busy.
- Write: we_i with waddr_i≠0 stores wdata_i and clears busy[waddr_i]. Writes to 0 are discarded.
- Allocate: alloc_i with alloc_rd_i≠0 sets busy[alloc_rd_i].
- Simultaneous write and allocate to the same index: allocate wins, so busy stays 1. The data is still written.
- flush_i clears every busy bit. It has priority over alloc_i in the same cycle, so the allocate is dropped. A write in the same cycle still stores data.
- Reset asserted mid-INIT or mid-RUN: restart INIT from entry 1. Storage contents are undefined until INIT completes.

## Timing
- Read latency: 0 cycles (combinational).
- Write, busy set and busy clear become visible on the edge after the request.
- Init duration: exactly NREGS-1 cycles after the first edge with rst_n_i high. ready_o rises on the following cycle.
- busy_o is a registered output and is never bypassed.

## Configuration
- REGFILE_BYPASS_EN defined: when we_i=1 and waddr_i==rs_i[p]≠0 in RUN:
  - rdata_o[p]=wdata_i
  - rs_busy_o[p]=0, unless alloc_i targets the same index that cycle.
- REGFILE_BYPASS_EN undefined: reads return the pre-write value, and rs_busy_o reflects registered busy only. Write-then-read needs one cycle.

## Structure
- Shared package regfile_pkg holds:
  - rf_state_e enum {INIT, RUN}
  - default XLEN/NREGS constants
  - rf_addr_t typedef
- Sub-module regfile_scoreboard holds the busy vector, alloc/release/flush priority logic and per-port busy lookup. The storage array and init FSM live in the top module.

## Test plan
- Reset released at cycle 0 with NREGS=32: ready_o low for cycles 1–31, high from cycle 32. Reading every index then returns 0.
- Write 0xDEADBEEF to x5, then read x5 on port 1 the next cycle: returns 0xDEADBEEF. A write of 0x1234 to x0 reads back as 0.
- Alloc x7; the next cycle rs_busy_o=1 and busy_o[7]=1. Write x7=0xA5 with alloc x7 in the same cycle: busy stays 1, data=0xA5.
- Alloc x3 and x9 over two cycles, then flush_i together with alloc x4: busy_o=0 afterwards, x4 not busy.
- With REGFILE_BYPASS_EN, write x10=0x55 while reading x10 on both ports: same-cycle rdata_o=0x55, rs_busy_o=0. Without the macro: old value is returned.
- Pulse rst_n_i low at cycle 10 of INIT: the init counter restarts, and ready_o rises NREGS-1 cycles after the release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the scoreboarded register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] rf_addr_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_scb_if.sv
// Read, writeback and issue-side signals of the register file.
interface regfile_scb_if #(
  parameter int XLEN  = regfile_pkg::XLEN_DEF,
  parameter int NREGS = regfile_pkg::NREGS_DEF,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD-1:0][AW-1:0]   rs;
  logic [NRD-1:0][XLEN-1:0] rdata;
  logic [NRD-1:0]           rs_busy;
  logic                     we;
  logic [AW-1:0]            waddr;
  logic [XLEN-1:0]          wdata;
  logic                     alloc;
  logic [AW-1:0]            alloc_rd;
  logic                     flush;

  modport master (
    output rs, we, waddr, wdata, alloc, alloc_rd, flush,
    input  rdata, rs_busy
  );

  modport slave (
    input  rs, we, waddr, wdata, alloc, alloc_rd, flush,
    output rdata, rs_busy
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: allocate sets, writeback clears, flush wins over both.
// Same-cycle writeback visibility on the read ports is enabled by REGFILE_BYPASS_EN.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   en_i,
  input  logic                   we_i,
  input  logic [$clog2(NREGS)-1:0] waddr_i,
  input  logic                   alloc_i,
  input  logic [$clog2(NREGS)-1:0] alloc_rd_i,
  input  logic                   flush_i,
  input  logic [NRD-1:0][$clog2(NREGS)-1:0] rs_i,
  output logic [NREGS-1:0]       busy_o,
  output logic [NRD-1:0]         rs_busy_o
);
  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0] busy_reg, busy_next;

  // Release is applied before allocate so a same-index pair leaves the bit set.
  always_comb begin
    busy_next = busy_reg;
    if (en_i) begin
      if (flush_i) begin
        busy_next = '0;
      end else begin
        if (we_i && waddr_i != '0)
          busy_next[waddr_i] = 1'b0;
        if (alloc_i && alloc_rd_i != '0)
          busy_next[alloc_rd_i] = 1'b1;
      end
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)
      busy_reg <= '0;
    else
      busy_reg <= busy_next;
  end

  assign busy_o = busy_reg;

  for (genvar gi = 0; gi < NRD; gi++) begin : g_port
    logic [AW-1:0] addr;
    logic          lookup;
    assign addr = rs_i[gi];
`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit    = we_i && (waddr_i == addr) && (addr != '0);
    assign lookup = hit ? (alloc_i && alloc_rd_i == addr) : busy_reg[addr];
`else
    assign lookup = busy_reg[addr];
`endif
    assign rs_busy_o[gi] = en_i && lookup;
  end

endmodule

// File: rtl/regfile_scb.sv
// Register file with unreset storage cleared by an init sequencer, plus busy scoreboard.
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile_scb
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  output logic             ready_o,
  output logic [NREGS-1:0] busy_o,
  regfile_scb_if.slave     bus
);
  localparam int AW = $clog2(NREGS);

  rf_state_e     state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic          init_we;
  logic          run;
  logic          wr_en;

  logic [XLEN-1:0] mem [NREGS];
  logic [NRD-1:0][XLEN-1:0] rdata;
  logic [NREGS-1:0]         busy;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg <= INIT;
      cnt_reg   <= AW'(1);
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    init_we    = 1'b0;
    case (state_reg)
      INIT: begin
        init_we  = rst_n_i;
        cnt_next = cnt_reg + AW'(1);
        if (cnt_reg == AW'(NREGS - 1))
          state_next = RUN;
      end
      RUN: ;
      default: state_next = INIT;
    endcase
  end

  assign run     = rst_n_i && (state_reg == RUN);
  assign ready_o = run;
  assign wr_en   = run && bus.we && (bus.waddr != '0);

  // Storage has no reset so it can live in distributed RAM.
  always_ff @(posedge clk_i) begin
    if (init_we)
      mem[cnt_reg] <= '0;
    else if (wr_en)
      mem[bus.waddr] <= bus.wdata;
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_read
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] word;
    assign addr = bus.rs[gi];
`ifdef REGFILE_BYPASS_EN
    assign word = (bus.we && bus.waddr == addr) ? bus.wdata : mem[addr];
`else
    assign word = mem[addr];
`endif
    assign rdata[gi] = (run && addr != '0) ? word : '0;
  end

  assign bus.rdata = rdata;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .en_i       (run),
    .we_i       (bus.we),
    .waddr_i    (bus.waddr),
    .alloc_i    (bus.alloc),
    .alloc_rd_i (bus.alloc_rd),
    .flush_i    (bus.flush),
    .rs_i       (bus.rs),
    .busy_o     (busy),
    .rs_busy_o  (bus.rs_busy)
  );

  assign busy_o = rst_n_i ? busy : '0;

endmodule

// File: tb/tb_regfile_scb.sv
// Directed bench for regfile_scb: init timing, read/write, scoreboard, forwarding, reset restart.
module tb_regfile_scb;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready;
  logic [31:0] busy;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  regfile_scb_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus ();

  regfile_scb #(.XLEN(32), .NREGS(32), .NRD(2)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .ready_o (ready),
    .busy_o  (busy),
    .bus     (bus)
  );

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        alloc;
    logic [4:0]  alloc_rd;
    logic        flush;
    logic [4:0]  rs0;
    logic [4:0]  rs1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  e_rsb;
    logic [31:0] e_busy;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                       input logic alloc, input logic [4:0] alloc_rd, input logic flush,
                       input logic [4:0] rs0, input logic [4:0] rs1);
    @(posedge clk);
    #1;
    bus.we = we; bus.waddr = waddr; bus.wdata = wdata;
    bus.alloc = alloc; bus.alloc_rd = alloc_rd; bus.flush = flush;
    bus.rs[0] = rs0; bus.rs[1] = rs1;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    $display("%s: ready after %0d edges", nm, n);
    chk(nm, 64'(n), 64'd31);
  endtask

  initial begin
    bus.we = 0; bus.waddr = 0; bus.wdata = 0; bus.alloc = 0; bus.alloc_rd = 0;
    bus.flush = 0; bus.rs[0] = 0; bus.rs[1] = 0;

    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  1'b0, 5'd0,  5'd6,  32'h0,        32'h0,        2'b00, 32'h0};
    vecs[1]  = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  1'b0, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 2'b00, 32'h0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b0, 5'd0,  5'd7,  32'h0,        32'h0,        2'b00, 32'h0};
    vecs[3]  = '{1'b1, 5'd7,  32'h000000A5, 1'b1, 5'd7,  1'b0, 5'd3,  5'd5,  32'h0,        32'hDEADBEEF, 2'b00, 32'h0000_0080};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 5'd7,  5'd0,  32'h000000A5, 32'h0,        2'b01, 32'h0000_0080};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd3,  5'd7,  32'h0,        32'h000000A5, 2'b11, 32'h0000_0088};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  1'b1, 5'd9,  5'd4,  32'h0,        32'h0,        2'b01, 32'h0000_0288};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd4,  5'd7,  32'h0,        32'h000000A5, 2'b00, 32'h0};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0};
    vecs[9]  = '{1'b1, 5'd12, 32'h0000CAFE, 1'b0, 5'd0,  1'b0, 5'd7,  5'd5,  32'h000000A5, 32'hDEADBEEF, 2'b00, 32'h0000_1000};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd12, 5'd12, 32'h0000CAFE, 32'h0000CAFE, 2'b00, 32'h0};

    // Reset held for a few edges, outputs forced low.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    wait_ready("init_len");

    for (int i = 0; i < 32; i++) begin
      bus.rs[0] = 5'(i);
      bus.rs[1] = 5'(31 - i);
      #1;
      chk($sformatf("init_zero_%0d", i), {bus.rdata[1], bus.rdata[0]}, 64'd0);
    end

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].alloc, vecs[i].alloc_rd,
            vecs[i].flush, vecs[i].rs0, vecs[i].rs1);
      #3;
      $display("vec %0d: rd0=%h rd1=%h rsb=%b busy=%h", i, bus.rdata[0], bus.rdata[1],
               bus.rs_busy, busy);
      chk($sformatf("vec%0d_rd0", i), 64'(bus.rdata[0]), 64'(vecs[i].e_rd0));
      chk($sformatf("vec%0d_rd1", i), 64'(bus.rdata[1]), 64'(vecs[i].e_rd1));
      chk($sformatf("vec%0d_rsb", i), 64'(bus.rs_busy), 64'(vecs[i].e_rsb));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
    end

    // Same-cycle write and read of x10 (x10 busy beforehand).
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 1'b0, 5'd0, 5'd0);
    drive(1'b1, 5'd10, 32'h55, 1'b0, 5'd0, 1'b0, 5'd10, 5'd10);
    #3;
    $display("bypass write x10: rd0=%h rd1=%h rsb=%b", bus.rdata[0], bus.rdata[1], bus.rs_busy);
`ifdef REGFILE_BYPASS_EN
    chk("byp_rd0", 64'(bus.rdata[0]), 64'h55);
    chk("byp_rd1", 64'(bus.rdata[1]), 64'h55);
    chk("byp_rsb", 64'(bus.rs_busy), 64'b00);
`else
    chk("byp_rd0", 64'(bus.rdata[0]), 64'h0);
    chk("byp_rd1", 64'(bus.rdata[1]), 64'h0);
    chk("byp_rsb", 64'(bus.rs_busy), 64'b11);
`endif
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd10, 5'd10);
    #3;
    chk("after_wr_rd", 64'(bus.rdata[0]), 64'h55);
    chk("after_wr_rsb", 64'(bus.rs_busy), 64'b00);
    drive(1'b1, 5'd10, 32'h66, 1'b1, 5'd10, 1'b0, 5'd10, 5'd0);
    #3;
    $display("bypass write+alloc x10: rd0=%h rsb=%b", bus.rdata[0], bus.rs_busy);
`ifdef REGFILE_BYPASS_EN
    chk("byp_alloc_rd", 64'(bus.rdata[0]), 64'h66);
    chk("byp_alloc_rsb", 64'(bus.rs_busy), 64'b01);
`else
    chk("byp_alloc_rd", 64'(bus.rdata[0]), 64'h55);
    chk("byp_alloc_rsb", 64'(bus.rs_busy), 64'b00);
`endif
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd10, 5'd5);
    #3;
    chk("wa_rd", 64'(bus.rdata[0]), 64'h66);
    chk("wa_rsb", 64'(bus.rs_busy), 64'b01);
    chk("wa_busy", 64'(busy), 64'h0000_0400);

    // Reset asserted mid-RUN: outputs drop at once, init restarts.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    $display("reset in RUN: ready=%b busy=%h rd0=%h", ready, busy, bus.rdata[0]);
    chk("mrun_ready", 64'(ready), 64'd0);
    chk("mrun_busy", 64'(busy), 64'd0);
    chk("mrun_rd", {bus.rdata[1], bus.rdata[0]}, 64'd0);
    chk("mrun_rsb", 64'(bus.rs_busy), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready("rerun_init_len");
    #1;
    chk("reinit_x10", 64'(bus.rdata[0]), 64'd0);
    chk("reinit_x5", 64'(bus.rdata[1]), 64'd0);
    chk("reinit_busy", 64'(busy), 64'd0);

    // Reset pulse ten edges into INIT.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("minit_notready", 64'(ready), 64'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready("minit_init_len");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
